// File: rtl/tt_um_proppy_bytebeat_pkg.sv
// Shared constants and formula-select encoding for the bytebeat generator.
package tt_um_proppy_bytebeat_pkg;

  localparam int T_W         = 24;    // sample counter width
  localparam int SAMPLE_W    = 8;     // audio sample width
  localparam int DIV_DEFAULT = 1250;  // clocks per sample: 8 kHz from 10 MHz
  localparam int DIV_W       = 16;    // divider counter width, covers DIV up to 65535

  // Formula selected by ui_in[2:0]
  typedef enum logic [2:0] {
    SEL_RAMP    = 3'd0,  // t
    SEL_MELODY  = 3'd1,  // t*((t>>12|t>>8)&63&t>>4)
    SEL_MIX     = 3'd2,  // (t*5&t>>7)|(t*3&t>>10)
    SEL_ARP     = 3'd3,  // t*((t>>9|t>>13)&25&t>>6)
    SEL_CHAOS   = 3'd4,  // (t>>6|t|t>>(t>>16))*10+(t>>11&7)
    SEL_BASS    = 3'd5,  // t*(t>>11&t>>8&123&t>>3)
    SEL_SIERP   = 3'd6,  // t&t>>8
    SEL_XOR     = 3'd7   // t^t>>8
  } sel_e;

endpackage

// File: rtl/tt_um_proppy_bytebeat_formula.sv
// Combinational bytebeat formula evaluator: sample = f(sel, t)[7:0],
// all arithmetic 24-bit unsigned, truncated mod 2^24.
module bytebeat_formula
  import tt_um_proppy_bytebeat_pkg::*;
(
  input  logic [T_W-1:0]      t_i,
  input  sel_e                sel_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [T_W-1:0] f_melody;
  logic [T_W-1:0] f_mix;
  logic [T_W-1:0] f_arp;
  logic [T_W-1:0] f_chaos;
  logic [T_W-1:0] f_bass;
  logic [T_W-1:0] f_sierp;
  logic [T_W-1:0] f_xor;
  logic [7:0]     chaos_sh;
  logic [T_W-1:0] chaos_var;
  logic [T_W-1:0] result;

  assign f_melody = t_i * (((t_i >> 12) | (t_i >> 8)) & 24'd63 & (t_i >> 4));
  assign f_mix    = ((t_i * 24'd5) & (t_i >> 7)) | ((t_i * 24'd3) & (t_i >> 10));
  assign f_arp    = t_i * (((t_i >> 9) | (t_i >> 13)) & 24'd25 & (t_i >> 6));
  assign f_bass   = t_i * ((t_i >> 11) & (t_i >> 8) & 24'd123 & (t_i >> 3));
  assign f_sierp  = t_i & (t_i >> 8);
  assign f_xor    = t_i ^ (t_i >> 8);

  // Data-dependent shift: amounts of 24 or more shift everything out.
  assign chaos_sh  = t_i[23:16];
  assign chaos_var = (chaos_sh >= 8'd24) ? '0 : (t_i >> chaos_sh);
  assign f_chaos   = ((t_i >> 6) | t_i | chaos_var) * 24'd10 + ((t_i >> 11) & 24'd7);

  // Select the active formula
  always_comb begin
    result = t_i;
    unique case (sel_i)
      SEL_RAMP:   result = t_i;
      SEL_MELODY: result = f_melody;
      SEL_MIX:    result = f_mix;
      SEL_ARP:    result = f_arp;
      SEL_CHAOS:  result = f_chaos;
      SEL_BASS:   result = f_bass;
      SEL_SIERP:  result = f_sierp;
      SEL_XOR:    result = f_xor;
      default:    result = t_i;
    endcase
  end

  assign sample_o = result[SAMPLE_W-1:0];

  // Only the low byte is audible; upper bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = &{1'b0, result[T_W-1:SAMPLE_W]};

endmodule

// File: rtl/tt_um_proppy_bytebeat.sv
// Bytebeat audio generator: sample-rate divider, 24-bit sample counter,
// registered formula output, sample strobe and 8-bit PWM audio.
module tt_um_proppy_bytebeat
  import tt_um_proppy_bytebeat_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT  // clocks per sample, legal 2..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                strobe_q, strobe_d;
  logic                pwm_q, pwm_d;
  logic                div_wrap;
  logic                advance;
  logic                pause;
  sel_e                sel;

  assign pause = ui_in[3];
  assign sel   = sel_e'(ui_in[2:0]);

  bytebeat_formula u_formula (
    .t_i      (t_q),
    .sel_i    (sel),
    .sample_o (sample_d)
  );

  // Next-state logic: divider always runs; t steps only on an enabled, unpaused wrap
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    advance   = div_wrap & ena & ~pause;
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    t_d       = advance ? t_q + T_W'(1) : t_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    strobe_d  = advance;
    pwm_d     = (pwm_cnt_q < sample_q);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      t_q       <= '0;
      pwm_cnt_q <= '0;
      sample_q  <= '0;
      strobe_q  <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      t_q       <= t_d;
      pwm_cnt_q <= pwm_cnt_d;
      sample_q  <= sample_d;
      strobe_q  <= strobe_d;
      pwm_q     <= pwm_d;
    end
  end

  assign uo_out  = sample_q;
  assign uio_out = {t_q[15:10], strobe_q, pwm_q};
  assign uio_oe  = 8'hFF;

  // Pins that carry no function in this design
  logic unused_inputs;
  assign unused_inputs = &{1'b0, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_proppy_bytebeat.sv
// Directed bench for tt_um_proppy_bytebeat with DIV=4.
module tb_tt_um_proppy_bytebeat;
  import tt_um_proppy_bytebeat_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Standalone formula instance for corner values of t unreachable in a short run
  logic [23:0] f_t;
  sel_e        f_sel;
  logic [7:0]  f_sample;

  int n_vec  = 0;
  int n_miss = 0;

  tt_um_proppy_bytebeat #(.DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  bytebeat_formula u_fref (
    .t_i      (f_t),
    .sel_i    (f_sel),
    .sample_o (f_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to_t(input logic [23:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (dut.t_q == target) break;
    end
    check_vec("reach_t", {8'h0, dut.t_q}, {8'h0, target});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic count_pwm(input string tag, input int exp_high);
    int highs;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      highs += int'(uio_out[0]);
    end
    check_vec(tag, highs, exp_high);
  endtask

  typedef struct {
    logic [23:0] t;
    logic [2:0]  sel;
    logic [7:0]  exp;
  } fvec_t;

  fvec_t fvecs[11] = '{
    '{24'h00FFFF, 3'd1, 8'hC1},
    '{24'h00FFFF, 3'd2, 8'hFF},
    '{24'h00FFFF, 3'd3, 8'hE7},
    '{24'h00FFFF, 3'd4, 8'hFD},
    '{24'h00FFFF, 3'd5, 8'hE5},
    '{24'h00FFFF, 3'd6, 8'hFF},
    '{24'h00FFFF, 3'd7, 8'h00},
    '{24'h000303, 3'd4, 8'h96},
    '{24'h100000, 3'd4, 8'hA0},
    '{24'h110000, 3'd4, 8'h50},
    '{24'h190000, 3'd4, 8'h00}
  };

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    f_t    = '0;
    f_sel  = SEL_RAMP;

    // Reset state
    tick(3);
    check_vec("rst_uo", uo_out, 8'h00);
    check_vec("rst_uio10", uio_out[1:0], 2'b00);
    check_vec("rst_t", dut.t_q, 24'h0);
    check_vec("uio_oe", uio_oe, 8'hFF);

    // First advance DIV edges after release, strobe one cycle wide
    rst_n = 1'b1;
    tick(3);
    check_vec("t_before", dut.t_q, 24'h0);
    check_vec("stb_before", uio_out[1], 1'b0);
    tick(1);
    check_vec("t_first", dut.t_q, 24'h1);
    check_vec("stb_on", uio_out[1], 1'b1);
    tick(1);
    check_vec("uo_first", uo_out, 8'h01);
    check_vec("stb_off", uio_out[1], 1'b0);
    tick(36);
    check_vec("uo_41", uo_out, 8'd10);

    // sel6/sel7 at chosen t values
    ui_in = 8'h06;
    run_to_t(24'd257, 4000);
    tick(1);
    check_vec("sel6_257", uo_out, 8'h01);
    run_to_t(24'h000303, 3000);
    tick(1);
    check_vec("sel6_303", uo_out, 8'h03);
    check_vec("uio_hi_303", uio_out[7:2], 6'h00);
    ui_in = 8'h07;
    tick(1);
    check_vec("sel7_303", uo_out, 8'h00);

    // Formula table on the standalone evaluator
    foreach (fvecs[i]) begin
      f_t   = fvecs[i].t;
      f_sel = sel_e'(fvecs[i].sel);
      #1;
      check_vec($sformatf("f%0d_%06h", fvecs[i].sel, fvecs[i].t), f_sample, fvecs[i].exp);
    end

    // Pause and ena-low freeze t; select still updates output
    ui_in = 8'h00;
    do_reset();
    run_to_t(24'd5, 100);
    ui_in = 8'h08;
    tick(20);
    check_vec("pause_t", dut.t_q, 24'd5);
    ui_in = 8'h0F;
    tick(1);
    check_vec("pause_sel7", uo_out, 8'h05);
    ui_in = 8'h07;
    ena   = 1'b0;
    tick(20);
    check_vec("ena0_t", dut.t_q, 24'd5);
    ena = 1'b1;
    tick(2);
    check_vec("resume_wait", dut.t_q, 24'd5);
    tick(1);
    check_vec("resume_step", dut.t_q, 24'd6);

    // PWM duty at uo_out==64 and at 0
    ui_in = 8'h00;
    do_reset();
    run_to_t(24'd64, 400);
    ui_in = 8'h08;
    tick(2);
    check_vec("pwm_uo64", uo_out, 8'd64);
    count_pwm("pwm_64", 64);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_vec("pwm_t0", dut.t_q, 24'h0);
    count_pwm("pwm_0", 0);

    // Reset mid-sample
    ui_in = 8'h00;
    do_reset();
    run_to_t(24'd9, 100);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_vec("mid_rst_t", dut.t_q, 24'h0);
    check_vec("mid_rst_uo", uo_out, 8'h00);
    rst_n = 1'b1;
    tick(3);
    check_vec("post_rst_stb0", uio_out[1], 1'b0);
    check_vec("post_rst_t0", dut.t_q, 24'h0);
    tick(1);
    check_vec("post_rst_stb1", uio_out[1], 1'b1);
    check_vec("post_rst_t1", dut.t_q, 24'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tt_um_proppy_bytebeat.md
TT_UM_PROPPY_BYTEBEAT -- requirements
Module: tt_um_proppy_bytebeat

Interface
REQ-001 Parameter DIV, default 1250, meaning clock cycles per audio sample (8 kHz at 10 MHz clk); legal range 2..65535.
REQ-002 clk  input  1  single clock; every register is updated on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 ena  input  1  design-selected enable; when low, the sample counter holds.
REQ-005 ui_in  input  8  [2:0] formula select, [3] pause, [7:4] unused.
REQ-006 uio_in  input  8  unused and ignored.
REQ-007 uo_out  output  8  current 8-bit sample value.
REQ-008 uio_out  output  8  [0] PWM audio, [1] sample strobe, [7:2] t[15:10].
REQ-009 uio_oe  output  8  constant 8'hFF (all uio pins are outputs).

Function
REQ-010 The block SHALL keep a 24-bit sample counter t and a divider counter div_cnt that counts 0..DIV-1.
REQ-011 div_cnt SHALL increment every clock and wrap to 0 after DIV-1, regardless of ena and pause.
REQ-012 Advance condition: div_cnt==DIV-1 and ena==1 and ui_in[3]==0; when it holds, t SHALL become t+1 (mod 2^24) on that edge.
REQ-013 t wrap-around: 24'hFFFFFF advances to 0 with no other side effect.
REQ-014 f(sel,t) SHALL use 24-bit unsigned arithmetic truncated mod 2^24; the output is bits [7:0]:
  sel0 t; sel1 t*((t>>12|t>>8)&63&t>>4); sel2 (t*5&t>>7)|(t*3&t>>10); sel3 t*((t>>9|t>>13)&25&t>>6);
  sel4 (t>>6|t|t>>(t>>16))*10+(t>>11&7), with shift amounts of 24 or more giving 0; sel5 t*(t>>11&t>>8&123&t>>3); sel6 t&t>>8; sel7 t^t>>8.
REQ-015 uo_out SHALL be a register loaded every clock with f(ui_in[2:0], t), using the pre-edge values of t and sel.
  Consequence: uo_out lags t by one clock, and a select change is visible one clock later.
REQ-016 The strobe uio_out[1] SHALL be registered and high for exactly the one cycle after each edge on which t advanced.
REQ-017 A free-running 8-bit pwm_cnt SHALL increment every clock; uio_out[0] SHALL be registered as (pwm_cnt < uo_out).
  Consequence: a duty cycle of uo_out/256, and a constant 0 when uo_out==0.
REQ-018 uio_out[7:2] SHALL equal t[15:10] combinationally.
REQ-019 Pause or ena low SHALL freeze t only; uo_out keeps following f(sel,t), so a select change while paused still updates uo_out.

Reset
REQ-020 While rst_n==0 at a rising edge, the following SHALL load 0: t, div_cnt, pwm_cnt, uo_out, strobe and the PWM bit. Reset has priority over every other action.
REQ-021 Reset asserted mid-sample SHALL discard the partial divider count; after rst_n rises, the first advance occurs DIV edges later.

Structure
REQ-022 A shared package SHALL hold constants T_W=24, SAMPLE_W=8 and DIV_DEFAULT=1250, plus the 3-bit formula-select enumeration.
REQ-023 The formula evaluation SHALL be a combinational sub-module bytebeat_formula(t, sel -> sample).
  Counters, PWM and output registers SHALL live in the top module.

Verification
REQ-024 DIV=4 bench, reset held 3 clocks -> uo_out, uio_out[1:0] and t all 0; uio_oe==8'hFF.
REQ-025 DIV=4, sel=0, ena=1, pause=0 -> t==1 after 4 edges from reset release; uo_out==1 one edge later; strobe high for exactly that one cycle; uo_out==10 after 41 edges.
REQ-026 DIV=4, sel=6, run to t==257 -> uo_out==1; at t==0x0303 -> uo_out==3; sel=7 at t==0x0303 -> uo_out==0.
REQ-027 Pause=1 or ena=0 for 20 clocks -> t unchanged; changing sel 0->7 at t==5 gives uo_out==5; resuming resumes stepping at the next div_cnt wrap.
REQ-028 Force uo_out==64 (sel0, t==64) -> uio_out[0] high for 64 of every 256 clocks; at t==0 -> uio_out[0] constantly low.
REQ-029 Assert rst_n low mid-sample at t==9 -> next edge gives t==0 and uo_out==0; strobe does not fire until DIV edges after release.
